alu_issue_ctrl: RTL and testbench

Operand capture and issue controller that sits between the touch-screen input path of the LCD module and the ALU. It latches control and source operands from `input_value`, and issues an operation to the ALU only on an explicit issue command, with a req/done handshake. It also tolerates multi-cycle ALUs, keeps a 4-deep result history and counters, and serves the LCD display-slot lookup with registered outputs.

---
 rtl/alu_issue_ctrl_if.sv | 22 ++
 rtl/alu_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// ALU-side bundle for the issue controller: registered operands out, done/result back.
interface alu_issue_ctrl_if #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 32
);
  logic              alu_req;
  logic [CTRL_W-1:0] alu_control;
  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;

  modport master (
    output alu_req, alu_control, alu_src1, alu_src2,
    input  alu_done, alu_result
  );

  modport slave (
    input  alu_req, alu_control, alu_src1, alu_src2,
    output alu_done, alu_result
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Touch-screen operand capture and ALU issue controller with result history
// and a registered LCD display-slot lookup.
//
// state  | meaning
// IDLE   | operands writable, waiting for issue command
// REQ    | alu_req high, waiting for done or timer terminal count
// DONE   | one cycle: shift history, bump op_count
module alu_issue_ctrl #(
  parameter int CTRL_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        input_valid,
  input  logic [31:0] input_value,
  input  logic [1:0]  input_sel,
  alu_issue_ctrl_if.master alu,
  output logic        busy,
  output logic [15:0] op_count,
  input  logic [5:0]  display_number,
  output logic        display_valid,
  output logic [39:0] display_name,
  output logic [31:0] display_value
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] src1_q, src2_q, res_q;
  logic [DATA_W-1:0] h0, h1, h2, h3;
  logic [7:0]        tmr, to_cnt, drop_cnt;
  logic              idle, issue, timed_out;

  assign idle      = (state == S_IDLE);
  assign issue     = idle && input_valid && (input_sel == 2'b01);
  assign timed_out = (state == S_REQ) && !alu.alu_done && (tmr == 8'd0);

  assign busy            = !idle;
  assign alu.alu_req     = (state == S_REQ);
  assign alu.alu_control = ctrl_q;
  assign alu.alu_src1    = src1_q;
  assign alu.alu_src2    = src2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (issue) state_nxt = S_REQ;
      S_REQ:   if (alu.alu_done || timed_out) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Timer is a down-counter loaded with TIMEOUT-1, so REQ lasts TIMEOUT cycles at most.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      res_q    <= '0;
      h0       <= '0;
      h1       <= '0;
      h2       <= '0;
      h3       <= '0;
      tmr      <= '0;
      to_cnt   <= '0;
      drop_cnt <= '0;
      op_count <= '0;
    end else begin
      if (idle && input_valid) begin
        case (input_sel)
          2'b00:   ctrl_q <= input_value[CTRL_W-1:0];
          2'b10:   src1_q <= DATA_W'(input_value);
          2'b11:   src2_q <= DATA_W'(input_value);
          default: ;
        endcase
      end
      if (!idle && input_valid && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;

      if (issue)                             tmr <= 8'(TIMEOUT - 1);
      else if (state == S_REQ && tmr != 8'd0) tmr <= tmr - 8'd1;

      if (state == S_REQ && alu.alu_done) begin
        res_q <= alu.alu_result;
      end else if (timed_out) begin
        res_q <= '1;
        if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
      end

      if (state == S_DONE) begin
        h3       <= h2;
        h2       <= h1;
        h1       <= h0;
        h0       <= res_q;
        op_count <= op_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
    end else begin
      display_valid <= 1'b1;
      display_name  <= '0;
      display_value <= '0;
      case (display_number)
        6'd1: begin display_name <= "SRC_1"; display_value <= 32'(src1_q); end
        6'd2: begin display_name <= "SRC_2"; display_value <= 32'(src2_q); end
        6'd3: begin display_name <= "CONTR"; display_value <= 32'(ctrl_q); end
        6'd4: begin display_name <= "RESUL"; display_value <= 32'(h0); end
        6'd5: begin display_name <= "HIST1"; display_value <= 32'(h1); end
        6'd6: begin display_name <= "HIST2"; display_value <= 32'(h2); end
        6'd7: begin display_name <= "HIST3"; display_value <= 32'(h3); end
        6'd8: begin display_name <= "COUNT"; display_value <= {16'd0, op_count}; end
        6'd9: begin display_name <= "STATS"; display_value <= {to_cnt, drop_cnt, 15'd0, busy}; end
        default: display_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: operand capture, issue handshake, timeout,
// drop counting, history, display map and asynchronous reset.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        input_valid = 1'b0;
  logic [31:0] input_value = '0;
  logic [1:0]  input_sel = '0;
  logic        busy;
  logic [15:0] op_count;
  logic [5:0]  display_number = '0;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;

  alu_issue_ctrl_if #(.CTRL_W(12), .DATA_W(32)) alu_bus ();

  alu_issue_ctrl #(.CTRL_W(12), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .resetn(resetn),
    .input_valid(input_valid), .input_value(input_value), .input_sel(input_sel),
    .alu(alu_bus),
    .busy(busy), .op_count(op_count),
    .display_number(display_number), .display_valid(display_valid),
    .display_name(display_name), .display_value(display_value)
  );

  always #50 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  logic [11:0] m_ctrl;
  logic [31:0] m_src1, m_src2;
  logic [31:0] m_hist[0:3];
  logic [15:0] m_ops;
  logic [7:0]  m_to, m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_ctrl = '0; m_src1 = '0; m_src2 = '0; m_ops = '0; m_to = '0; m_drop = '0;
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_clear();
  endtask

  task automatic send(input logic [1:0] sel, input logic [31:0] val);
    @(posedge clk); #1;
    input_valid = 1'b1; input_sel = sel; input_value = val;
    @(posedge clk); #1;
    input_valid = 1'b0;
  endtask

  task automatic read_slot(input int n);
    display_number = 6'(n);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [39:0] slot_name(input int n);
    case (n)
      1: return "SRC_1";
      2: return "SRC_2";
      3: return "CONTR";
      4: return "RESUL";
      5: return "HIST1";
      6: return "HIST2";
      7: return "HIST3";
      8: return "COUNT";
      9: return "STATS";
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] slot_value(input int n);
    case (n)
      1: return m_src1;
      2: return m_src2;
      3: return {20'd0, m_ctrl};
      4: return m_hist[0];
      5: return m_hist[1];
      6: return m_hist[2];
      7: return m_hist[3];
      8: return {16'd0, m_ops};
      9: return {m_to, m_drop, 16'd0};
      default: return '0;
    endcase
  endfunction

  // Issues one op and plays the ALU: done rises on REQ cycle lat+1 unless never is set.
  task automatic run_op(input int lat, input logic [31:0] res, input bit never, input bit inject,
                        output int req_n, output int busy_n);
    bit fin;
    fin = 1'b0;
    exp_q.push_back(never ? 32'hFFFF_FFFF : res);
    send(2'b01, 32'd0);
    req_n = 0;
    busy_n = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!busy) begin fin = 1'b1; break; end
      busy_n++;
      if (alu_bus.alu_req) req_n++;
      alu_bus.alu_done   = alu_bus.alu_req && !never && (req_n == lat + 1);
      alu_bus.alu_result = res;
      input_valid = inject && (busy_n == 3);
      input_sel   = 2'b10;
      input_value = 32'hAAAA_AAAA;
    end
    alu_bus.alu_done = 1'b0;
    input_valid = 1'b0;
    chk("op_finished", 64'(fin), 64'd1);
    if (inject && m_drop != 8'hFF) m_drop++;
    if (never && m_to != 8'hFF) m_to++;
    m_ops++;
  endtask

  task automatic check_result();
    logic [31:0] e;
    read_slot(4);
    chk("scoreboard_nonempty", 64'(exp_q.size() > 0), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = e;
    chk("slot4_result", 64'(display_value), 64'(e));
  endtask

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rq, bs;
    alu_bus.alu_done = 1'b0;
    alu_bus.alu_result = '0;
    model_clear();

    // reset state
    @(posedge clk); @(negedge clk);
    chk("rst_req", 64'(alu_bus.alu_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_opcnt", 64'(op_count), 64'd0);
    chk("rst_src1", 64'(alu_bus.alu_src1), 64'd0);
    chk("rst_dvalid", 64'(display_valid), 64'd0);
    do_reset();

    // basic op with a combinational ALU
    send(2'b10, 32'h0000_0005); m_src1 = 32'h5;
    send(2'b11, 32'h0000_0003); m_src2 = 32'h3;
    send(2'b00, 32'hFFFF_F001); m_ctrl = 12'h001;
    chk("src1_load", 64'(alu_bus.alu_src1), 64'h5);
    chk("src2_load", 64'(alu_bus.alu_src2), 64'h3);
    chk("ctrl_load", 64'(alu_bus.alu_control), 64'h001);
    run_op(0, 32'h8, 1'b0, 1'b0, rq, bs);
    chk("op1_req_cycles", 64'(rq), 64'd1);
    chk("op1_busy_cycles", 64'(bs), 64'd2);
    chk("op1_opcnt", 64'(op_count), 64'd1);
    check_result();

    // five ops, results 1..5, mixed latency
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      run_op(i % 3, 32'(i), 1'b0, 1'b0, rq, bs);
      chk("multi_req_cycles", 64'(rq), 64'((i % 3) + 1));
      check_result();
    end
    read_slot(5); chk("hist1", 64'(display_value), 64'd4);
    read_slot(6); chk("hist2", 64'(display_value), 64'd3);
    read_slot(7); chk("hist3", 64'(display_value), 64'd2);
    read_slot(8); chk("count5", 64'(display_value), 64'd5);

    // write while busy is dropped
    send(2'b10, 32'h1234_5678); m_src1 = 32'h1234_5678;
    run_op(10, 32'h77, 1'b0, 1'b1, rq, bs);
    chk("drop_src1_frozen", 64'(alu_bus.alu_src1), 64'h1234_5678);
    chk("drop_req_cycles", 64'(rq), 64'd11);
    chk("drop_busy_cycles", 64'(bs), 64'd12);
    check_result();
    read_slot(9); chk("drop_stats", 64'(display_value), 64'h0001_0000);

    // timeout
    run_op(0, 32'h0, 1'b1, 1'b0, rq, bs);
    chk("to_req_cycles", 64'(rq), 64'd255);
    chk("to_busy_cycles", 64'(bs), 64'd256);
    check_result();
    read_slot(9); chk("to_stats", 64'(display_value), 64'h0101_0000);
    chk("to_opcnt", 64'(op_count), 64'(m_ops));

    // done outside REQ is ignored
    alu_bus.alu_done = 1'b1; alu_bus.alu_result = 32'h99;
    repeat (3) begin
      @(negedge clk);
      chk("idle_done_busy", 64'(busy), 64'd0);
    end
    alu_bus.alu_done = 1'b0;
    chk("idle_done_opcnt", 64'(op_count), 64'(m_ops));

    // display sweep
    send(2'b00, 32'h0000_0ABC); m_ctrl = 12'hABC;
    for (int n = 0; n <= 12; n++) begin
      read_slot(n);
      chk($sformatf("sweep_valid_%0d", n), 64'(display_valid), 64'((n >= 1 && n <= 9) ? 1 : 0));
      chk($sformatf("sweep_name_%0d", n), 64'(display_name), 64'(slot_name(n)));
      chk($sformatf("sweep_value_%0d", n), 64'(display_value), 64'(slot_value(n)));
    end

    // asynchronous reset in the middle of REQ
    send(2'b01, 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_req_active", 64'(alu_bus.alu_req), 64'd1);
    #5 resetn = 1'b0;
    #1;
    chk("async_req", 64'(alu_bus.alu_req), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_opcnt", 64'(op_count), 64'd0);
    chk("async_src1", 64'(alu_bus.alu_src1), 64'd0);
    chk("async_ctrl", 64'(alu_bus.alu_control), 64'd0);
    chk("async_dvalue", 64'(display_value), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_clear();
    for (int n = 1; n <= 9; n++) begin
      read_slot(n);
      chk($sformatf("post_rst_slot_%0d", n), 64'(display_value), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
